// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state, line-select and parity-type constants for the UART TX frame sequencer.
package uart_tx_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;
   localparam logic [1:0] SEL_START = 2'b00;
   localparam logic [1:0] SEL_STOP  = 2'b01;
   localparam logic [1:0] SEL_DATA  = 2'b10;
   localparam logic [1:0] SEL_PAR   = 2'b11;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity bit for a data word, even or odd.
module uart_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] p_data_i,
   input  logic                  par_typ_i,
   output logic                  par_bit_o
);
   assign par_bit_o = (par_typ_i == PAR_ODD) ? ~^p_data_i : ^p_data_i;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer; drives start/data/parity/stop onto the line and gates the serializer.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  Data_Valid,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_data,
   input  logic                  ser_done,
   output logic                  ser_en,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  overrun
);
   state_e     state_q;
   logic       par_en_q;
   logic       par_bit_q;
   logic       overrun_q;
   logic       par_bit_d;
   logic       accept;
   logic [1:0] sel;
   uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
      .p_data_i  (P_DATA),
      .par_typ_i (PAR_TYP),
      .par_bit_o (par_bit_d)
   );
   assign accept  = Data_Valid && (state_q == IDLE || state_q == STOP);
   assign ser_en  = (state_q == DATA);
   assign busy    = state_q inside {START, DATA, PARITY, STOP};
   assign overrun = overrun_q;
   // Illegal encodings fall through to SEL_STOP, i.e. an idle-high line.
   always_comb begin
      sel    = (state_q == START) ? SEL_START :
               (state_q == DATA)  ? SEL_DATA  :
               (state_q == PARITY) ? SEL_PAR  : SEL_STOP;
      TX_OUT = (sel == SEL_START) ? 1'b0 :
               (sel == SEL_DATA)  ? ser_data :
               (sel == SEL_PAR)   ? par_bit_q : 1'b1;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= Data_Valid && !accept;
         if (accept) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_d;
         end
         case (state_q)
            IDLE:    state_q <= accept ? START : IDLE;
            START:   state_q <= DATA;
            DATA:    state_q <= ser_done ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_q <= STOP;
            STOP:    state_q <= accept ? START : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench; expected per-cycle line/enable records come from a frame-level model.
module tb_uart_tx_ctrl;
   typedef struct {
      logic tx;
      logic en;
      logic mid;
   } rec_t;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       Data_Valid = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       ser_data, ser_done, ser_en, TX_OUT, busy, overrun;
   logic       ser_ld = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic [7:0] sh;
   logic [2:0] cnt;
   rec_t       q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic       prev_dv = 1'b0;
   logic       prev_mid = 1'b0;
   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Data_Valid (Data_Valid),
      .P_DATA     (P_DATA),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .ser_data   (ser_data),
      .ser_done   (ser_done),
      .ser_en     (ser_en),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .overrun    (overrun)
   );
   always #5 clk = ~clk;
   // Serializer stand-in: loads only on accepted requests so the line stays defined after an overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh  <= 8'h00;
         cnt <= 3'd0;
      end else if (ser_ld) begin
         sh  <= ld_data;
         cnt <= 3'd0;
      end else if (ser_en) begin
         sh  <= sh >> 1;
         cnt <= cnt + 3'd1;
      end
   end
   assign ser_data = sh[0];
   assign ser_done = (cnt == 3'd7);
   task automatic chk(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask
   task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
      q.push_back('{1'b0, 1'b0, 1'b1});
      for (int i = 0; i < 8; i++) q.push_back('{d[i], 1'b1, 1'b1});
      if (pe) q.push_back('{logic'(($countones(d) % 2 == 1) ^ pt), 1'b0, 1'b1});
      q.push_back('{1'b1, 1'b0, 1'b0});
   endtask
   task automatic scramble();
      P_DATA  = 8'($urandom);
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk) #1;
         scramble();
      end
   endtask
   // Called at posedge+1; returns at posedge+1 of the following cycle (START when accepted).
   task automatic pulse(input logic [7:0] d, input logic pe, input logic pt, input logic acc);
      Data_Valid = 1'b1;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      ser_ld     = acc;
      ld_data    = d;
      @(posedge clk) #1;
      Data_Valid = 1'b0;
      ser_ld     = 1'b0;
      scramble();
      if (acc) push_frame(d, pe, pt);
   endtask
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_tx", TX_OUT, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ser_en", ser_en, 1'b0);
      q.delete();
      @(posedge clk);
      @(posedge clk) #1 reset_n = 1'b1;
   endtask
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_dv  = 1'b0;
         prev_mid = 1'b0;
      end else begin
         rec_t r;
         chk("overrun", overrun, prev_dv && prev_mid);
         if (q.size() != 0) begin
            r = q.pop_front();
            chk("busy_in_frame", busy, 1'b1);
            chk("tx_line", TX_OUT, r.tx);
            chk("ser_en", ser_en, r.en);
            prev_mid = r.mid;
         end else begin
            chk("busy_idle", busy, 1'b0);
            chk("tx_idle", TX_OUT, 1'b1);
            chk("ser_en_idle", ser_en, 1'b0);
            prev_mid = 1'b0;
         end
         prev_dv = Data_Valid;
      end
   end
   initial begin
      #1;
      chk("por_tx", TX_OUT, 1'b1);
      chk("por_busy", busy, 1'b0);
      chk("por_ser_en", ser_en, 1'b0);
      chk("por_overrun", overrun, 1'b0);
      @(posedge clk) #1;
      @(posedge clk) #1 reset_n = 1'b1;
      tick(2);
      pulse(8'hA5, 1'b0, 1'b0, 1'b1); tick(10);
      pulse(8'hA5, 1'b1, 1'b0, 1'b1); tick(11);
      pulse(8'hA5, 1'b1, 1'b1, 1'b1); tick(11);
      pulse(8'h07, 1'b1, 1'b0, 1'b1); tick(11);
      pulse(8'h55, 1'b0, 1'b0, 1'b1); tick(9);
      pulse(8'hAA, 1'b0, 1'b0, 1'b1); tick(10);
      pulse(8'h3C, 1'b1, 1'b1, 1'b1); tick(3);
      pulse(8'($urandom), 1'b0, 1'b0, 1'b0); tick(7);
      pulse(8'hC3, 1'b0, 1'b0, 1'b1); tick(3);
      do_reset();
      tick(1);
      pulse(8'h5A, 1'b1, 1'b0, 1'b1); tick(11);
      for (int k = 0; k < 40; k++) begin
         logic [7:0] d;
         logic       pe, pt;
         int         gap;
         d   = 8'($urandom);
         pe  = 1'($urandom);
         pt  = 1'($urandom);
         gap = int'($urandom_range(0, 2));
         pulse(d, pe, pt, 1'b1);
         tick(9 + int'(pe) + gap);
      end
      tick(12);
      chk("queue_drained", q.size() == 0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
